// File: rtl/vp_pixel_serializer.sv
// Per-character row serialiser: a one-entry holding register feeds an MSB-first
// shifter that emits one 4-bit colour index per pixel clock-enable.
module vp_pixel_serializer #(
  parameter int BITMAP_WIDTH = 16,
  parameter int COUNT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pixel_ce,
  input  logic                    flush,
  input  logic                    double_width,
  input  logic [3:0]              txt_foreground,
  input  logic [3:0]              txt_background,
  input  logic [BITMAP_WIDTH-1:0] txt_bitmap,
  input  logic                    enable,
  output logic                    load_ready,
  output logic [3:0]              pixel_index,
  output logic                    pixel_valid,
  output logic                    underflow,
  output logic                    overrun
);

  localparam logic [COUNT_WIDTH-1:0] LP_CNT_1X = COUNT_WIDTH'(BITMAP_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] LP_CNT_2X = COUNT_WIDTH'(2 * BITMAP_WIDTH - 1);

  logic                    r_hold_full;
  logic [3:0]              r_hold_fg;
  logic [3:0]              r_hold_bg;
  logic [BITMAP_WIDTH-1:0] r_hold_bmp;
  logic [3:0]              r_sh_fg;
  logic [3:0]              r_sh_bg;
  logic [BITMAP_WIDTH-1:0] r_sh_bmp;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_phase;
  logic                    r_dw;
  logic [3:0]              r_pixel_index;
  logic                    r_pixel_valid;
  logic                    r_underflow;
  logic                    r_overrun;

  logic                    w_busy;

  assign w_busy      = (r_count != '0);
  assign load_ready  = !r_hold_full;
  assign pixel_index = r_pixel_index;
  assign pixel_valid = r_pixel_valid;
  assign underflow   = r_underflow;
  assign overrun     = r_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full   <= 1'b0;
      r_hold_fg     <= '0;
      r_hold_bg     <= '0;
      r_hold_bmp    <= '0;
      r_sh_fg       <= '0;
      r_sh_bg       <= '0;
      r_sh_bmp      <= '0;
      r_count       <= '0;
      r_phase       <= 1'b0;
      r_dw          <= 1'b0;
      r_pixel_index <= '0;
      r_pixel_valid <= 1'b0;
      r_underflow   <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (flush) begin
      r_hold_full   <= 1'b0;
      r_count       <= '0;
      r_phase       <= 1'b0;
      r_pixel_index <= '0;
      r_pixel_valid <= 1'b0;
      r_underflow   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      // Capture qualifies on the pre-transfer hold state, so a transfer and a
      // capture can never both touch r_hold_full in the same cycle.
      if (enable) begin
        if (!r_hold_full) begin
          r_hold_fg   <= txt_foreground;
          r_hold_bg   <= txt_background;
          r_hold_bmp  <= txt_bitmap;
          r_hold_full <= 1'b1;
        end else begin
          r_overrun   <= 1'b1;
        end
      end

      if (!pixel_ce) begin
        r_pixel_valid <= 1'b0;
      end else if (w_busy) begin
        r_pixel_index <= r_sh_bmp[BITMAP_WIDTH-1] ? r_sh_fg : r_sh_bg;
        r_pixel_valid <= 1'b1;
        r_count       <= r_count - COUNT_WIDTH'(1);
        if (r_dw && !r_phase) begin
          r_phase <= 1'b1;
        end else begin
          r_sh_bmp <= {r_sh_bmp[BITMAP_WIDTH-2:0], 1'b0};
          r_phase  <= 1'b0;
        end
      end else if (r_hold_full) begin
        // First pixel comes straight from hold so rows join without a bubble.
        r_pixel_index <= r_hold_bmp[BITMAP_WIDTH-1] ? r_hold_fg : r_hold_bg;
        r_pixel_valid <= 1'b1;
        r_sh_fg       <= r_hold_fg;
        r_sh_bg       <= r_hold_bg;
        r_dw          <= double_width;
        r_hold_full   <= 1'b0;
        r_count       <= double_width ? LP_CNT_2X : LP_CNT_1X;
        if (double_width) begin
          r_sh_bmp <= r_hold_bmp;
          r_phase  <= 1'b1;
        end else begin
          r_sh_bmp <= {r_hold_bmp[BITMAP_WIDTH-2:0], 1'b0};
          r_phase  <= 1'b0;
        end
      end else begin
        r_pixel_index <= '0;
        r_pixel_valid <= 1'b0;
        r_underflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vp_pixel_serializer.sv
// Directed bench for vp_pixel_serializer: expected pixels are queued as rows are
// issued and a negedge monitor pops and compares every valid pixel.
module tb_vp_pixel_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_ce;
  logic        flush;
  logic        double_width;
  logic [3:0]  txt_foreground;
  logic [3:0]  txt_background;
  logic [15:0] txt_bitmap;
  logic        enable;
  logic        load_ready;
  logic [3:0]  pixel_index;
  logic        pixel_valid;
  logic        underflow;
  logic        overrun;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [3:0]  exp_q[$];

  vp_pixel_serializer #(.BITMAP_WIDTH(16), .COUNT_WIDTH(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pixel_ce       (pixel_ce),
    .flush          (flush),
    .double_width   (double_width),
    .txt_foreground (txt_foreground),
    .txt_background (txt_background),
    .txt_bitmap     (txt_bitmap),
    .enable         (enable),
    .load_ready     (load_ready),
    .pixel_index    (pixel_index),
    .pixel_valid    (pixel_valid),
    .underflow      (underflow),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_row(input logic [3:0] fg, input logic [3:0] bg,
                          input logic [15:0] bmp, input logic dw);
    for (int i = 15; i >= 0; i--) begin
      exp_q.push_back(bmp[i] ? fg : bg);
      if (dw) exp_q.push_back(bmp[i] ? fg : bg);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input logic [3:0] fg, input logic [3:0] bg, input logic [15:0] bmp);
    enable         = 1'b1;
    txt_foreground = fg;
    txt_background = bg;
    txt_bitmap     = bmp;
  endtask

  task automatic do_flush();
    pixel_ce = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && pixel_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel: got %0h expected none at %0t", pixel_index, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (pixel_index !== e) begin
          bad++;
          $display("FAIL pixel: got %0h expected %0h at %0t", pixel_index, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ce;
    reset_n = 1'b0; pixel_ce = 1'b0; flush = 1'b0; double_width = 1'b0;
    txt_foreground = '0; txt_background = '0; txt_bitmap = '0; enable = 1'b0;
    #2;
    check("rst_index", pixel_index, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_ready", load_ready, 1);
    check("rst_flags", {underflow, overrun}, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single row, 1x
    drive_row(4'hA, 4'h3, 16'h8001); push_row(4'hA, 4'h3, 16'h8001, 1'b0);
    tick();
    enable = 1'b0;
    check("t1_full", load_ready, 0);
    pixel_ce = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("t1_no_uflow", underflow, 0);
    tick();
    check("t1_end_valid", pixel_valid, 0);
    check("t1_uflow", underflow, 1);
    check("t1_drain", exp_q.size(), 0);

    // Back-to-back rows, gap-free
    do_flush();
    check("t2_flush_uflow", underflow, 0);
    drive_row(4'h5, 4'h9, 16'hFFFF); push_row(4'h5, 4'h9, 16'hFFFF, 1'b0);
    tick();
    enable = 1'b0; pixel_ce = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("t2_valid", pixel_valid, 1);
      if (i == 0) begin
        check("t2_ready", load_ready, 1);
        drive_row(4'hE, 4'h2, 16'h0000); push_row(4'hE, 4'h2, 16'h0000, 1'b0);
      end else begin
        enable = 1'b0;
      end
    end
    check("t2_uflow", underflow, 0);
    tick();
    check("t2_drain", exp_q.size(), 0);

    // Double width, pixel_ce every 3rd cycle
    do_flush();
    double_width = 1'b1;
    drive_row(4'hF, 4'h0, 16'hC000); push_row(4'hF, 4'h0, 16'hC000, 1'b1);
    tick();
    enable = 1'b0;
    n_ce = 0;
    for (int c = 0; c < 99; c++) begin
      pixel_ce = (c % 3 == 0) && (n_ce < 32);
      if (pixel_ce) n_ce++;
      tick();
      check("t3_valid", pixel_valid, pixel_ce);
    end
    pixel_ce = 1'b0; double_width = 1'b0;
    tick();
    check("t3_drain", exp_q.size(), 0);
    check("t3_uflow", underflow, 0);

    // Overrun while shifter busy and hold full
    do_flush();
    drive_row(4'h9, 4'h6, 16'h0F0F); push_row(4'h9, 4'h6, 16'h0F0F, 1'b0);
    tick();
    enable = 1'b0; pixel_ce = 1'b1;
    tick();
    drive_row(4'h1, 4'hE, 16'hF0F0); push_row(4'h1, 4'hE, 16'hF0F0, 1'b0);
    tick();
    check("t4_full", load_ready, 0);
    check("t4_no_ovr", overrun, 0);
    drive_row(4'h7, 4'h8, 16'h1234);
    tick();
    enable = 1'b0;
    check("t4_ovr", overrun, 1);
    for (int i = 0; i < 31; i++) tick();
    check("t4_uflow", underflow, 1);
    check("t4_ovr_sticky", overrun, 1);
    check("t4_drain", exp_q.size(), 0);

    // Flush mid-row with hold full; flags set from previous section
    pixel_ce = 1'b0;
    drive_row(4'hC, 4'h4, 16'hAAAA);
    for (int i = 0; i < 5; i++) exp_q.push_back((i % 2 == 0) ? 4'hC : 4'h4);
    tick();
    enable = 1'b0; pixel_ce = 1'b1;
    tick();
    drive_row(4'h1, 4'h1, 16'hFFFF);
    tick();
    drive_row(4'h2, 4'h2, 16'h5555);
    tick();
    enable = 1'b0;
    tick(); tick();
    check("t5_pre_flags", {underflow, overrun}, 2'b11);
    check("t5_pre_full", load_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_valid", pixel_valid, 0);
    check("t5_ready", load_ready, 1);
    check("t5_flags", {underflow, overrun}, 0);
    check("t5_index", pixel_index, 0);
    tick();
    check("t5_uflow", underflow, 1);
    check("t5_valid2", pixel_valid, 0);
    check("t5_drain", exp_q.size(), 0);

    // Async reset mid-shift
    do_flush();
    drive_row(4'hB, 4'hD, 16'h00FF);
    for (int i = 0; i < 3; i++) exp_q.push_back(4'hD);
    tick();
    enable = 1'b0; pixel_ce = 1'b1;
    tick(); tick(); tick();
    pixel_ce = 1'b0;
    tick();
    check("t6_pre_index", pixel_index, 4'hD);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_index", pixel_index, 0);
    check("t6_valid", pixel_valid, 0);
    check("t6_ready", load_ready, 1);
    check("t6_flags", {underflow, overrun}, 0);
    #3;
    reset_n = 1'b1;
    tick();
    drive_row(4'h6, 4'h1, 16'h8000); push_row(4'h6, 4'h1, 16'h8000, 1'b0);
    tick();
    enable = 1'b0; pixel_ce = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    pixel_ce = 1'b0;
    tick();
    check("t6_drain", exp_q.size(), 0);
    check("t6_uflow", underflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vp_pixel_serializer.md
Name: vp_pixel_serializer

Overview:
- Downstream neighbour of the text pattern stage. Consumes its registered per-character row: 4-bit foreground, 4-bit background, 16-bit bitmap and an enable strobe.
- Serialises each row into one 4-bit colour index per pixel slot, MSB first, at a pixel clock-enable rate.
- A one-entry holding register double-buffers input, so the next character can be captured while the current one shifts out. The palette/DAC stage is fed gap-free.

Parameters:
- BITMAP_WIDTH, 16, pixels per character row; the shifter width.
- COUNT_WIDTH, 6, width of the slot counter; must hold 2*BITMAP_WIDTH.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pixel_ce  in  1  pixel clock enable; one pixel slot per high cycle
- flush  in  1  synchronous line-start flush
- double_width  in  1  each bitmap bit lasts 2 pixel slots; sampled at transfer
- txt_foreground  in  4  colour index for set bits
- txt_background  in  4  colour index for clear bits
- txt_bitmap  in  16  row bitmap; bit 15 is the leftmost pixel
- enable  in  1  input valid strobe
- load_ready  out  1  holding register empty; input accepted this cycle
- pixel_index  out  4  registered colour index
- pixel_valid  out  1  registered; pixel_index is a real pixel
- underflow  out  1  sticky; slot occurred with no data
- overrun  out  1  sticky; enable while load_ready low

Behaviour:
- Reset (async, reset_n=0) clears:
  - hold_full, shifter, slot count, phase and dw_latched
  - outputs: pixel_index=0, pixel_valid=0, underflow=0, overrun=0
  - load_ready therefore reads 1.
- load_ready is a direct function of hold_full: load_ready = !hold_full. It does not depend on any input in the same cycle.
- Capture: when enable=1 and load_ready=1, hold_fg, hold_bg and hold_bmp load from the inputs, and hold_full becomes 1 the next cycle.
- Capture while full: when enable=1 and load_ready=0, the input is dropped, hold is unchanged, and overrun is set to 1.
- pixel_ce=0:
  - pixel_valid <= 0; pixel_index holds its value.
  - Shifter, count and phase are unchanged.
- pixel_ce=1 with count!=0 (SHIFT):
  - pixel_index <= sh_bmp[15] ? sh_fg : sh_bg; pixel_valid <= 1; count <= count-1.
  - If dw_latched=1 and phase=0: phase <= 1 and no shift.
  - Otherwise: sh_bmp shifts left by 1 (zero fill) and phase <= 0.
- pixel_ce=1 with count=0 and hold_full=1 (TRANSFER):
  - Shifter loads from hold; dw_latched <= double_width; hold_full <= 0.
  - The first pixel is emitted in the same cycle from hold_bmp[15], so there is no bubble between characters.
  - count <= (double_width ? 32 : 16) - 1.
  - phase/shift rules apply as in SHIFT, using the new dw value.
- pixel_ce=1 with count=0 and hold_full=0 (STARVED):
  - pixel_index <= 0; pixel_valid <= 0; underflow <= 1.
- TRANSFER and capture in the same cycle:
  - The capture qualifier is the pre-transfer load_ready, which is 0 here, so the input is not accepted and overrun is set.
  - The upstream stage must honour load_ready.
- Latency: a capture at cycle N gives hold_full at N+1.
  - If the shifter is empty, the first valid pixel is registered on the next pixel_ce at or after N+1 and is visible on the following cycle.
- flush=1 takes priority over everything:
  - Clears hold_full, count, phase, pixel_valid, underflow and overrun.
  - Any capture in that cycle is ignored.
  - pixel_index <= 0.
- Sticky flags clear only on reset or flush.
- The slot count never wraps; decrement occurs only when count!=0.

Test Plan:
- Single row, 1x width:
  - Stimulus: after reset, load fg=0xA, bg=0x3, bmp=0x8001; hold pixel_ce=1.
  - Expected: 16 valid pixels A,3,3,…,3,A, then pixel_valid=0 and underflow=1.
- Back-to-back rows:
  - Stimulus: load bmp=0xFFFF (fg=0x5), then capture bmp=0x0000 (bg=0x2) as soon as load_ready rises; pixel_ce=1 throughout.
  - Expected: 16×5 immediately followed by 16×2, pixel_valid high for 32 consecutive cycles, underflow=0.
- Double width with throttled rate:
  - Stimulus: pixel_ce on every 3rd cycle; double_width=1; bmp=0xC000, fg=0xF, bg=0x0.
  - Expected: valid pixels F,F,F,F, then 28×0; pixel_valid pulses only in the cycle after each pixel_ce.
- Overrun:
  - Stimulus: with the shifter busy and hold_full=1, pulse enable with bmp=0x1234.
  - Expected: overrun=1, the held data is unchanged, and 0x1234 is never emitted.
- Flush mid-row:
  - Stimulus: assert flush after the 5th pixel of a 0xAAAA row, with hold_full=1.
  - Expected: next cycle pixel_valid=0, load_ready=1, flags=0; the following pixel_ce with empty hold sets underflow.
- Async reset mid-shift:
  - Stimulus: drop reset_n between clock edges.
  - Expected: outputs go to 0 immediately and load_ready=1; after release, a new row serialises from bit 15.
